// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types for the PC-generation / instruction-bus request stage.
// Holds the fetch FSM encoding, reset PC and ibus bundles.
package pc_fetch_ctrl_pkg;

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  localparam logic [63:0] PCINIT_DEFAULT =
    64'h0000_0000_8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/pc_fetch_ctrl_fetch_buf.sv
// Registered output buffer presenting {valid, pc, raw_instr}.
// Load wins over clear; otherwise the contents hold.
module pc_fetch_ctrl_fetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [63:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [63:0] o_pc,
  output logic [31:0] o_instr
);

  logic        r_valid;
  logic [63:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC generation with a single-outstanding instruction-bus request.
// Redirects during an in-flight request are deferred until data_ok.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] PCINIT = PCINIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_raw_instr
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [63:0]  r_pc;
  logic [63:0]  w_pc_nxt;
  logic         r_redirect_pending;
  logic         w_pend_nxt;
  logic [63:0]  r_redirect_target;
  logic [63:0]  w_tgt_nxt;
  logic         w_buf_load;
  logic         w_buf_clear;
  logic         w_kill;
  logic [63:0]  w_new_target;
  ibus_req_t    w_ireq;
  ibus_resp_t   w_iresp;

  assign w_iresp = {iresp_data_ok, iresp_data};
  assign w_ireq  = {(r_state == REQ) & ~reset, r_pc};

  assign ireq_valid = w_ireq.valid;
  assign ireq_addr  = w_ireq.addr;

  assign w_kill = r_redirect_pending | redirect_valid;
  // A redirect in the current cycle beats the latched one
  assign w_new_target = redirect_valid ? redirect_pc
                                       : r_redirect_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= REQ;
      r_pc               <= PCINIT;
      r_redirect_pending <= 1'b0;
      r_redirect_target  <= '0;
    end else begin
      r_state            <= w_state_nxt;
      r_pc               <= w_pc_nxt;
      r_redirect_pending <= w_pend_nxt;
      r_redirect_target  <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_redirect_pending;
    w_tgt_nxt   = r_redirect_target;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    unique case (r_state)
      REQ: begin
        if (w_iresp.data_ok) begin
          if (w_kill) begin
            w_pc_nxt   = w_new_target;
            w_pend_nxt = 1'b0;
          end else begin
            w_buf_load  = 1'b1;
            w_pc_nxt    = r_pc + 64'd4;
            w_state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          w_pend_nxt = 1'b1;
          w_tgt_nxt  = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_buf_clear = 1'b1;
          w_pc_nxt    = redirect_pc;
          w_state_nxt = REQ;
        end else if (!stall_i) begin
          w_buf_clear = 1'b1;
          w_state_nxt = REQ;
        end
      end
      default: begin
        w_state_nxt = REQ;
      end
    endcase
  end

  pc_fetch_ctrl_fetch_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_pc    (r_pc),
    .i_instr (w_iresp.data),
    .o_valid (out_valid),
    .o_pc    (out_pc),
    .o_instr (out_raw_instr)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl.
// Expected addresses/outputs are queued and popped as the DUT responds.
module tb_pc_fetch_ctrl;

  localparam logic [63:0] PCI = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_raw_instr;

  int checks = 0;
  int failures = 0;

  logic [63:0] q_addr[$];
  logic [95:0] q_out[$];

  pc_fetch_ctrl #(.PCINIT(PCI)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_raw_instr  (out_raw_instr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall_i = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    iresp_data_ok = 1'b0;
    iresp_data = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    q_addr.delete();
    q_out.delete();
    q_addr.push_back(PCI);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ireq_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Holds the request lat cycles, then returns data for one cycle.
  task automatic serve(input int lat, input logic [31:0] d,
                       output bit stable);
    logic [63:0] a;
    a = ireq_addr;
    stable = 1'b1;
    repeat (lat) begin
      tick();
      if (!ireq_valid || ireq_addr !== a) stable = 1'b0;
    end
    iresp_data_ok = 1'b1;
    iresp_data = d;
    tick();
    iresp_data_ok = 1'b0;
    iresp_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall_i = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    iresp_data_ok = 1'b1;
    iresp_data = 32'hDEAD_BEEF;
    tick();
    tick();
    checks++;
    if (ireq_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_ireq_valid got=%b exp=0", ireq_valid);
    end
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'd0 ||
        out_raw_instr !== 32'd0) begin
      failures++;
      $display("FAIL rst_out got=%b/%h/%h exp=0/0/0",
               out_valid, out_pc, out_raw_instr);
    end
    iresp_data_ok = 1'b0;
    iresp_data = '0;
    reset = 1'b0;
    #1;
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== PCI) begin
      failures++;
      $display("FAIL rst_first_req got=%b/%h exp=1/%h",
               ireq_valid, ireq_addr, PCI);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    bit st;
    logic [63:0] ea;
    logic [95:0] eo;
    logic [31:0] d;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_req(ok);
      ea = q_addr.pop_front();
      checks++;
      if (!ok || ireq_addr !== ea) begin
        failures++;
        $display("FAIL seq_addr%0d got=%b/%h exp=1/%h",
                 k, ok, ireq_addr, ea);
      end
      q_addr.push_back(ea + 64'd4);
      d = 32'h1000_0013 + 32'(k);
      q_out.push_back({ea, d});
      serve(2, d, st);
      checks++;
      if (!st) begin
        failures++;
        $display("FAIL seq_stable%0d got=0 exp=1", k);
      end
      eo = q_out.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_pc, out_raw_instr} !== eo ||
          ireq_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_out%0d got=%b/%h/%h req=%b exp=1/%h/%h",
                 k, out_valid, out_pc, out_raw_instr, ireq_valid,
                 eo[95:32], eo[31:0]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_consume%0d got=%b exp=0", k, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    bit st;
    logic [95:0] eo;
    do_reset();
    serve(1, 32'hAAAA_0001, st);
    tick();
    q_out.push_back({PCI + 64'd4, 32'hAAAA_0002});
    serve(1, 32'hAAAA_0002, st);
    stall_i = 1'b1;
    eo = q_out.pop_front();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || {out_pc, out_raw_instr} !== eo ||
          ireq_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d got=%b/%h/%h req=%b exp=1/%h/%h",
                 i, out_valid, out_pc, out_raw_instr, ireq_valid,
                 eo[95:32], eo[31:0]);
      end
    end
    stall_i = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 ||
        ireq_addr !== PCI + 64'd8) begin
      failures++;
      $display("FAIL stall_release got=%b/%b/%h exp=0/1/%h",
               out_valid, ireq_valid, ireq_addr, PCI + 64'd8);
    end
  endtask

  task automatic test_redirect_inflight();
    bit st;
    do_reset();
    serve(1, 32'h0000_0001, st);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    redirect_pc = '0;
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== PCI + 64'd4) begin
      failures++;
      $display("FAIL rdin_hold got=%b/%h exp=1/%h",
               ireq_valid, ireq_addr, PCI + 64'd4);
    end
    serve(2, 32'h0BAD_0BAD, st);
    checks++;
    if (!st) begin
      failures++;
      $display("FAIL rdin_stable got=0 exp=1");
    end
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 ||
        ireq_addr !== 64'h8000_1000) begin
      failures++;
      $display("FAIL rdin_after got=%b/%b/%h exp=0/1/80001000",
               out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_2000;
    iresp_data_ok = 1'b1;
    iresp_data = 32'h0BAD_F00D;
    tick();
    redirect_valid = 1'b0;
    iresp_data_ok = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 ||
        ireq_addr !== 64'h8000_2000) begin
      failures++;
      $display("FAIL rdsame got=%b/%b/%h exp=0/1/80002000",
               out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_redirect_hold();
    bit st;
    do_reset();
    serve(1, 32'h1111_2222, st);
    stall_i = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== PCI) begin
      failures++;
      $display("FAIL rdhold_pre got=%b/%h exp=1/%h",
               out_valid, out_pc, PCI);
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_3000;
    tick();
    redirect_valid = 1'b0;
    stall_i = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 ||
        ireq_addr !== 64'h8000_3000) begin
      failures++;
      $display("FAIL rdhold got=%b/%b/%h exp=0/1/80003000",
               out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_two_redirects();
    bit st;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect_pc = 64'h200;
    tick();
    redirect_valid = 1'b0;
    tick();
    serve(1, 32'h3333_4444, st);
    checks++;
    if (!st || out_valid !== 1'b0 || ireq_valid !== 1'b1 ||
        ireq_addr !== 64'h200) begin
      failures++;
      $display("FAIL two_rd got=%b/%b/%b/%h exp=1/0/1/200",
               st, out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit st;
    do_reset();
    serve(1, 32'h5555_6666, st);
    tick();
    tick();
    reset = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data = 32'h7777_8888;
    #1;
    checks++;
    if (ireq_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_req got=%b exp=0", ireq_valid);
    end
    tick();
    reset = 1'b0;
    iresp_data_ok = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 ||
        ireq_addr !== PCI) begin
      failures++;
      $display("FAIL rstmid_restart got=%b/%b/%h exp=0/1/%h",
               out_valid, ireq_valid, ireq_addr, PCI);
    end
  endtask

  task automatic test_wrap();
    bit st;
    logic [95:0] eo;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    iresp_data_ok = 1'b1;
    tick();
    redirect_valid = 1'b0;
    iresp_data_ok = 1'b0;
    q_out.push_back({64'hFFFF_FFFF_FFFF_FFFC, 32'h9999_0000});
    serve(1, 32'h9999_0000, st);
    eo = q_out.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_pc, out_raw_instr} !== eo) begin
      failures++;
      $display("FAIL wrap_out got=%b/%h/%h exp=1/%h/%h",
               out_valid, out_pc, out_raw_instr, eo[95:32], eo[31:0]);
    end
    tick();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'd0) begin
      failures++;
      $display("FAIL wrap_addr got=%b/%h exp=1/0",
               ireq_valid, ireq_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_redirect_hold();
    test_two_redirects();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- PC-generation and instruction-bus request stage, directly upstream of fetch.
- Owns the architectural fetch PC and runs a single-outstanding instruction-bus request.
- Captures the returned instruction word and presents {valid, pc, raw_instr} in a registered output buffer; fetch packs these into fetch_data_t.
- Handles downstream stall and branch/exception redirects, including redirects that arrive while a bus request is in flight.

Parameters:
- PCINIT, 64'h0000_0000_8000_0000, PC of the first request after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  downstream cannot accept; hold current output
- redirect_valid  in  1  one-cycle pulse; discard fetch stream and restart at redirect_pc
- redirect_pc  in  64  redirect target
- ireq_valid  out  1  instruction-bus request valid
- ireq_addr  out  64  instruction-bus request address
- iresp_data_ok  in  1  bus returns data this cycle for the outstanding request
- iresp_data  in  32  returned instruction word; meaningful only when iresp_data_ok=1
- out_valid  out  1  output buffer holds a live instruction
- out_pc  out  64  PC of the buffered instruction
- out_raw_instr  out  32  buffered instruction word

Behaviour:
- Reset, synchronous, active-high: pc=PCINIT, state=REQ, out_valid=0, out_pc=0, out_raw_instr=0, redirect_pending=0, redirect_target=0.
- In the cycle reset is high, ireq_valid=0. The first request (addr PCINIT) appears in the first cycle after reset deasserts.
- Bus rule: once ireq_valid is raised, ireq_valid and ireq_addr stay constant until the cycle iresp_data_ok=1. A request is never withdrawn or re-addressed mid-flight.
- ireq_valid=1 iff state==REQ and reset is low. ireq_addr=pc.
- kill = redirect_pending | redirect_valid.
- Target selection on kill: new_target = redirect_pc if redirect_valid is high this cycle, else redirect_target. The current-cycle redirect always beats the latched one.
- State REQ, no data_ok:
  - If redirect_valid: latch redirect_pending=1 and redirect_target=redirect_pc. pc and ireq_addr stay unchanged.
  - The output buffer is untouched, since it is empty in REQ.
- State REQ, data_ok and !kill:
  - out_valid<=1, out_pc<=pc, out_raw_instr<=iresp_data.
  - pc<=pc+4 (modulo 2^64, wraps silently).
  - Next state HOLD.
- State REQ, data_ok and kill:
  - Drop the data; out_valid stays 0.
  - pc<=new_target; redirect_pending<=0.
  - Stay in REQ. The new request is issued the next cycle.
- State HOLD: ireq_valid=0; out_valid=1.
  - redirect_valid: out_valid<=0, pc<=redirect_pc, then REQ. Redirect beats stall.
  - Else stall_i: hold everything.
  - Else (consumed): out_valid<=0, then REQ.
- Latency:
  - Instruction appears on the outputs 1 cycle after data_ok.
  - Best-case throughput is one instruction per 2 cycles plus bus latency.
- The output buffer is always registered; no combinational path from iresp_* to out_*.
- redirect_pc is used as-is; misalignment is handled downstream.
- Reset mid-request: the outstanding request is abandoned. The bus is reset by the same signal, and a stale data_ok arriving in the reset cycle is ignored.

Decomposition:
- Package pipes:
  - fetch_state_t enum {REQ, HOLD}
  - PCINIT default constant
- Package common: the existing ibus request/response typedefs. The top-level wrapper maps ireq_*/iresp_* onto them.
- Sub-module fetch_buf: the output register (load / clear / hold) with its own reset. All other logic stays flat.

Test Plan:
- Reset release, data_ok 2 cycles after every request, stall_i=0 -> ireq_addr sequence 0x80000000, 0x80000004, 0x80000008; out_pc follows one cycle after each data_ok, with matching out_raw_instr.
- Hold stall_i=1 for 5 cycles in HOLD -> outputs frozen, ireq_valid=0 throughout; on release, next request is addr 0x80000008.
- redirect_valid with redirect_pc=0x80001000 while a request to 0x80000004 is pending and data_ok 3 cycles later -> ireq_addr stays 0x80000004 until data_ok, data discarded with out_valid=0, next request 0x80001000.
- redirect_valid in the same cycle as data_ok -> data dropped, next ireq_addr = redirect_pc.
- Redirect in HOLD with stall_i=1 -> out_valid clears next cycle and the next request goes to the redirect target.
- Two redirects (0x100, then 0x200) while a request is in flight -> latest wins, next ireq_addr=0x200.
- Reset asserted mid-request -> ireq_valid=0 that cycle, then a restart at PCINIT.
- pc=0xFFFF_FFFF_FFFF_FFFC consumed -> next request addr 0x0.
